// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue.
// Fetch FSM states, FIFO entry layout and the address helper.
package ifq_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  function automatic logic [ADDR_W-1:0] align(
    input logic [ADDR_W-1:0] a
  );
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc,inst} entries for the fetch queue.
// Head entry reads straight from storage and reads as zero when empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the PC, one outstanding imem request,
// buffers responses for decode and restarts on redirect.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              gnt_ok;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              credit;
  entry_t            wr_entry;
  entry_t            rd_entry;

  assign credit = (count < CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (gnt_ok) state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)         state_nxt = FETCH;
        else if (redirect_valid) state_nxt = DROP;
      end
      DROP:    if (imem_rvalid) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Request is masked during reset so memory sees no fetch
  always_comb begin
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state)
      FETCH:   imem_req = rst_n && credit && !redirect_valid;
      WAIT:    push = imem_rvalid && !redirect_valid;
      default: ;
    endcase
    gnt_ok = imem_req && imem_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      if (redirect_valid)  fetch_pc <= align(redirect_pc);
      else if (gnt_ok)     fetch_pc <= fetch_pc + 32'd4;
      if (gnt_ok)          req_pc   <= fetch_pc;
    end
  end

  assign imem_addr = fetch_pc;

  assign wr_entry.pc   = req_pc;
  assign wr_entry.inst = imem_rdata;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign inst_valid = !empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = rd_entry.inst;
  assign inst_pc    = rd_entry.pc;

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) push |-> !full
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: per-cycle vector tables plus
// hand-written redirect and reset sequences against a memory model.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: evaluates 2 time units after each falling edge
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          grants = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wcnt = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pend        = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pend) begin
        if (wcnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(paddr);
          pend        = 1'b0;
        end else begin
          wcnt = wcnt - 1;
        end
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        pend   = 1'b1;
        paddr  = imem_addr;
        wcnt   = lat;
        grants = grants + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic g, input logic r, input logic rd,
                     input logic [31:0] rp);
    @(negedge clk);
    gnt_en         = g;
    inst_ready     = r;
    redirect_valid = rd;
    redirect_pc    = rp;
    #3;
  endtask

  task automatic reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic g, input logic r, input logic q,
                     input logic [31:0] a, input logic v,
                     input logic [31:0] p);
    vec_t e;
    e.gnt = g; e.rdy = r; e.req = q;
    e.addr = a; e.vld = v; e.pc = p;
    tbl.push_back(e);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(tbl[i].gnt, tbl[i].rdy, 1'b0, '0);
      chk($sformatf("r%0d.req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("r%0d.addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("r%0d.vld", i), 32'(inst_valid), 32'(tbl[i].vld));
      chk($sformatf("r%0d.pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("r%0d.data", i), inst_data,
          tbl[i].vld ? word(tbl[i].pc) : 32'h0);
    end
  endtask

  int g0;

  initial begin
    // streaming, ready=1, rows 0..8
    add(1,1, 1,32'h00, 0,32'h0);
    add(1,1, 0,32'h04, 0,32'h0);
    add(1,1, 1,32'h04, 1,32'h0);
    add(1,1, 0,32'h08, 0,32'h0);
    add(1,1, 1,32'h08, 1,32'h4);
    add(1,1, 0,32'h0C, 0,32'h0);
    add(1,1, 1,32'h0C, 1,32'h8);
    add(1,1, 0,32'h10, 0,32'h0);
    add(1,1, 1,32'h10, 1,32'hC);
    // fill to full with ready=0, rows 9..18
    add(1,0, 1,32'h00, 0,32'h0);
    add(1,0, 0,32'h04, 0,32'h0);
    add(1,0, 1,32'h04, 1,32'h0);
    add(1,0, 0,32'h08, 1,32'h0);
    add(1,0, 1,32'h08, 1,32'h0);
    add(1,0, 0,32'h0C, 1,32'h0);
    add(1,0, 1,32'h0C, 1,32'h0);
    add(1,0, 0,32'h10, 1,32'h0);
    add(1,0, 0,32'h10, 1,32'h0);
    add(1,0, 0,32'h10, 1,32'h0);
    // drain and resume, rows 19..24
    add(1,1, 0,32'h10, 1,32'h0);
    add(1,1, 1,32'h10, 1,32'h4);
    add(1,1, 0,32'h14, 1,32'h8);
    add(1,1, 1,32'h14, 1,32'hC);
    add(1,1, 0,32'h18, 1,32'h10);
    add(1,1, 1,32'h18, 1,32'h14);

    #2;
    chk("rst.req", 32'(imem_req), 32'h0);
    chk("rst.vld", 32'(inst_valid), 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.pc", inst_pc, 32'h0);
    chk("rst.data", inst_data, 32'h0);

    reset();
    run(0, 8);

    reset();
    g0 = grants;
    run(9, 18);
    chk("full.grants", 32'(grants - g0), 32'd4);
    run(19, 24);

    // grant withheld: address holds, pc does not advance
    reset();
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk($sformatf("stall%0d.req", k), 32'(imem_req), 32'h1);
      chk($sformatf("stall%0d.addr", k), imem_addr, 32'h0);
    end
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("stall.gnt.addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("stall.adv.addr", imem_addr, 32'h4);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("stall.vld", 32'(inst_valid), 32'h1);
    chk("stall.pc", inst_pc, 32'h0);
    chk("stall.data", inst_data, word(32'h0));

    // redirect while waiting on a slow response
    reset();
    lat = 1;
    repeat (4) cyc(1'b1, 1'b0, 1'b0, '0);
    lat = 5;
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("rdw.pre.vld", 32'(inst_valid), 32'h1);
    chk("rdw.pre.addr", imem_addr, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("rdw.vld", 32'(inst_valid), 32'h0);
    chk("rdw.req", 32'(imem_req), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("rdw.flush.vld", 32'(inst_valid), 32'h0);
    chk("rdw.flush.pc", inst_pc, 32'h0);
    chk("rdw.addr", imem_addr, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("rdw.drop1.req", 32'(imem_req), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("rdw.drop2.req", 32'(imem_req), 32'h0);
    chk("rdw.drop2.vld", 32'(inst_valid), 32'h0);
    lat = 1;
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("rdw.refetch.req", 32'(imem_req), 32'h1);
    chk("rdw.refetch.addr", imem_addr, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("rdw.first.vld", 32'(inst_valid), 32'h1);
    chk("rdw.first.pc", inst_pc, 32'h100);
    chk("rdw.first.data", inst_data, word(32'h100));

    // redirect in the same cycle as the response
    reset();
    lat = 1;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("rdr.rvalid", 32'(imem_rvalid), 32'h1);
    chk("rdr.vld", 32'(inst_valid), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("rdr.next.vld", 32'(inst_valid), 32'h0);
    chk("rdr.next.req", 32'(imem_req), 32'h1);
    chk("rdr.next.addr", imem_addr, 32'h200);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("rdr.first.pc", inst_pc, 32'h200);
    chk("rdr.first.vld", 32'(inst_valid), 32'h1);

    // asynchronous reset mid-WAIT with two entries queued
    reset();
    lat = 1;
    repeat (4) cyc(1'b1, 1'b0, 1'b0, '0);
    lat = 5;
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("ar.pre.vld", 32'(inst_valid), 32'h1);
    chk("ar.pre.pc", inst_pc, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.vld", 32'(inst_valid), 32'h0);
    chk("ar.data", inst_data, 32'h0);
    chk("ar.pc", inst_pc, 32'h0);
    chk("ar.req", 32'(imem_req), 32'h0);
    chk("ar.addr", imem_addr, 32'h0);
    lat = 1;
    reset();
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("ar.post.req", 32'(imem_req), 32'h1);
    chk("ar.post.addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0);
    chk("ar.post.pc", inst_pc, 32'h0);
    chk("ar.post.data", inst_data, word(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle core's decode, register-file and ALU path.
- Owns the fetch PC and issues word requests to a latency-variable instruction memory using a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode under valid/ready.
- Flushes and restarts on branch/jump redirect from the execute stage.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  returned instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  head FIFO entry valid.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  decode consumes the head entry.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, state=FETCH, count=0, rd/wr pointers=0.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
- States: FETCH (may request), WAIT (one request in flight), DROP (in-flight response to be discarded).
- At most one outstanding request at any time.
- FETCH:
  - imem_req = (count < DEPTH) and not redirect_valid.
  - imem_addr = fetch_pc.
  - imem_req & imem_gnt -> latch req_pc=fetch_pc, fetch_pc += 4 (wraps modulo 2^32), go to WAIT.
- Address stability: while imem_req=1 and imem_gnt=0, imem_addr holds steady. A redirect is the only exception; it deasserts req for that cycle.
- WAIT:
  - imem_req=0.
  - imem_rvalid -> push {req_pc, imem_rdata}, go to FETCH.
  - Minimum gnt-to-rvalid latency is 1 cycle; unbounded wait is allowed.
- Credit: a request is only issued when count < DEPTH, and a push only follows its own request. A push into a full FIFO is therefore impossible; the implementation asserts this.
- Back-to-back: best case is one instruction per 2 cycles (gnt cycle, then rvalid cycle). Request in cycle t, push visible at inst_valid in cycle t+2 with 1-cycle rvalid latency.
- Output:
  - inst_valid = (count != 0) and not redirect_valid.
  - inst_data / inst_pc are the head entry, registered FIFO storage; they show 0 when empty.
  - Pop when inst_valid & inst_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (highest priority, evaluated every cycle):
  - count=0, pointers reset, pop suppressed, fetch_pc=redirect_pc&~3.
  - In FETCH -> stay in FETCH. Next cycle, request redirect_pc.
  - In WAIT without rvalid in the same cycle -> DROP.
  - In WAIT with rvalid in the same cycle -> data discarded, go to FETCH.
  - In DROP -> stay in DROP; the pending response is still discarded.
- DROP: imem_req=0. On imem_rvalid -> discard, go to FETCH.
- Spurious imem_rvalid in FETCH is ignored (no push).
- Reset mid-operation: all state cleared asynchronously. The instruction memory shares rst_n, so no response survives reset.
- Widths:
  - count is $clog2(DEPTH)+1 bits.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package ifq_pkg: state enum (FETCH, WAIT, DROP), INST_W=32, ADDR_W=32, default RESET_PC.
- Sub-module ifq_fifo: synchronous FIFO with DEPTH param, 64-bit entry {pc,inst}, push/pop/flush, count, full/empty.
- ifetch_queue holds the FSM, fetch_pc and credit logic.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, inst_ready=1 -> imem_addr sequence 0,4,8,C. inst_pc matches the address; inst_data equals the memory model word; first inst_valid 2 cycles after the first request.
- inst_ready=0, DEPTH=4 -> exactly 4 grants, then imem_req held 0 with count=4. Raise inst_ready -> entries drain in order, PCs 0,4,8,C, and fetch resumes at 0x10.
- gnt held 0 for 3 cycles -> imem_req=1 and imem_addr stable over all 3 cycles; fetch_pc does not advance until gnt.
- Redirect to 0x0000_0103 while in WAIT with 5-cycle rvalid latency -> FIFO emptied, that response discarded, next request addr 0x0000_0100, first delivered inst_pc 0x100.
- redirect_valid and imem_rvalid in the same cycle -> no push, inst_valid=0 next cycle, next request at the redirect target.
- Assert rst_n=0 asynchronously mid-WAIT with 2 entries queued -> outputs zero immediately, count=0. After release, the first request is RESET_PC.
